// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect-4 game sequencer.
package c4_pkg;

    localparam int C4_COLS = 7;
    localparam int C4_ROWS = 6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        WRITE     = 3'd2,
        CHECK     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

endpackage

// File: rtl/c4_btn_edge.sv
// Rising-edge detector for one synchronous button level.
module c4_btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic btn_edge
);

    logic btn_q;

    // Remember the level seen at the previous edge.
    always_ff @(posedge clock) begin
        if (reset) btn_q <= 1'b0;
        else       btn_q <= btn;
    end

    assign btn_edge = btn & ~btn_q;

endmodule

// File: rtl/c4_turn_ctrl.sv
// Connect-4 game sequencer: cursor, drops, column heights, turns, game end.
// Optional macro C4_CURSOR_WRAP_EN: cursor wraps at the board edges instead
// of saturating.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for the first start press
// SELECT    | player moves the cursor and may drop a piece
// WRITE     | write request held until the board store grants it
// CHECK     | waiting for the win checker verdict on the last piece
// GAME_OVER | win or draw reached; start begins a new game
module c4_turn_ctrl
    import c4_pkg::*;
#(
    parameter int COLS = C4_COLS,
    parameter int ROWS = C4_ROWS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    output logic       wr_req,
    input  logic       wr_gnt,
    output logic [2:0] wr_col,
    output logic [2:0] wr_row,
    output logic       wr_player,
    output logic       chk_start,
    input  logic       chk_done,
    input  logic       chk_win,
    output logic [2:0] cursor_col,
    output logic       cur_player,
    output logic       col_full,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int HW = $clog2(ROWS + 1);
    localparam int MW = $clog2(COLS * ROWS + 1);

    localparam logic [2:0]    CUR_HOME = 3'(COLS / 2);
    localparam logic [2:0]    CUR_LAST = 3'(COLS - 1);
    localparam logic [HW-1:0] H_FULL   = HW'(ROWS);
    localparam logic [MW-1:0] M_ALL    = MW'(COLS * ROWS);

`ifdef C4_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic start_e, left_e, right_e, drop_e;

    c4_btn_edge u_edge_start (.clock(clock), .reset(reset), .btn(start),     .btn_edge(start_e));
    c4_btn_edge u_edge_left  (.clock(clock), .reset(reset), .btn(btn_left),  .btn_edge(left_e));
    c4_btn_edge u_edge_right (.clock(clock), .reset(reset), .btn(btn_right), .btn_edge(right_e));
    c4_btn_edge u_edge_drop  (.clock(clock), .reset(reset), .btn(btn_drop),  .btn_edge(drop_e));

    state_t                   state, state_n;
    logic [2:0]               cursor, cursor_n;
    logic                     player, player_n;
    logic [COLS-1:0][HW-1:0]  heights, heights_n;
    logic [MW-1:0]            moves, moves_n;
    logic                     wr_req_n, wr_player_n, chk_start_n, col_full_n;
    logic [2:0]               wr_col_n, wr_row_n;
    logic [1:0]               winner_n;

    // Next-state and next-register values; every register holds by default,
    // the one-cycle pulses default low.
    always_comb begin
        state_n     = state;
        cursor_n    = cursor;
        player_n    = player;
        heights_n   = heights;
        moves_n     = moves;
        wr_req_n    = wr_req;
        wr_col_n    = wr_col;
        wr_row_n    = wr_row;
        wr_player_n = wr_player;
        winner_n    = winner;
        chk_start_n = 1'b0;
        col_full_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start_e) state_n = SELECT;
            end

            SELECT: begin
                if (drop_e) begin
                    if (heights[cursor] == H_FULL) begin
                        col_full_n = 1'b1;
                    end else begin
                        wr_col_n    = cursor;
                        wr_row_n    = 3'(heights[cursor]);
                        wr_player_n = player;
                        wr_req_n    = 1'b1;
                        state_n     = WRITE;
                    end
                end else if (left_e && !right_e) begin
                    if (cursor == 3'd0) cursor_n = WRAP ? CUR_LAST : 3'd0;
                    else                cursor_n = cursor - 3'd1;
                end else if (right_e && !left_e) begin
                    if (cursor == CUR_LAST) cursor_n = WRAP ? 3'd0 : CUR_LAST;
                    else                    cursor_n = cursor + 3'd1;
                end
            end

            WRITE: begin
                if (wr_gnt) begin
                    heights_n[wr_col] = heights[wr_col] + HW'(1);
                    moves_n           = moves + MW'(1);
                    wr_req_n          = 1'b0;
                    chk_start_n       = 1'b1;
                    state_n           = CHECK;
                end
            end

            CHECK: begin
                if (chk_done) begin
                    if (chk_win) begin
                        winner_n = player ? WIN_P2 : WIN_P1;
                        state_n  = GAME_OVER;
                    end else if (moves == M_ALL) begin
                        winner_n = WIN_DRAW;
                        state_n  = GAME_OVER;
                    end else begin
                        player_n = ~player;
                        state_n  = SELECT;
                    end
                end
            end

            GAME_OVER: begin
                if (start_e) begin
                    heights_n = '0;
                    moves_n   = '0;
                    player_n  = 1'b0;
                    cursor_n  = CUR_HOME;
                    winner_n  = WIN_NONE;
                    state_n   = SELECT;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Register update; reset overrides any state including WRITE and CHECK.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cursor    <= CUR_HOME;
            player    <= 1'b0;
            heights   <= '0;
            moves     <= '0;
            wr_req    <= 1'b0;
            wr_col    <= 3'd0;
            wr_row    <= 3'd0;
            wr_player <= 1'b0;
            chk_start <= 1'b0;
            col_full  <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            state     <= state_n;
            cursor    <= cursor_n;
            player    <= player_n;
            heights   <= heights_n;
            moves     <= moves_n;
            wr_req    <= wr_req_n;
            wr_col    <= wr_col_n;
            wr_row    <= wr_row_n;
            wr_player <= wr_player_n;
            chk_start <= chk_start_n;
            col_full  <= col_full_n;
            winner    <= winner_n;
        end
    end

    assign cursor_col = cursor;
    assign cur_player = player;
    assign game_over  = (state == GAME_OVER);

endmodule
